// File: rtl/rggen_rtl_pkg.sv
// Shared bus types for the rggen register blocks, plus the round-robin grant
// helper used by the bus arbiter and any other arbiter that needs it.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_READ         = 2'b00,
    RGGEN_WRITE        = 2'b01,
    RGGEN_POSTED_WRITE = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rggen_bus_arbiter_state;

  localparam int RGGEN_RR_MAX_HOSTS = 32;

  // Returns a one-hot grant for the first request found after last_grant,
  // wrapping at hosts-1; all zero when nothing is requested.
  function automatic logic [RGGEN_RR_MAX_HOSTS-1:0] rggen_rr_select(
    input logic [RGGEN_RR_MAX_HOSTS-1:0] requests,
    input logic [4:0]                    last_grant,
    input logic [5:0]                    hosts
  );
    logic [RGGEN_RR_MAX_HOSTS-1:0] grant;
    logic [6:0]                    idx;
    logic                          found;
    grant = '0;
    found = 1'b0;
    for (int i = 1; i <= RGGEN_RR_MAX_HOSTS; i++) begin
      idx = {2'b00, last_grant} + 7'(i);
      if (idx >= {1'b0, hosts}) begin
        idx = idx - {1'b0, hosts};
      end
      if (!found && (7'(i) <= {1'b0, hosts}) && requests[idx[4:0]]) begin
        grant[idx[4:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rggen_round_robin_selector.sv
// Round-robin selector: combinational rotate-priority pick over the request
// vector, with a registered pointer to the last host whose transaction completed.
module rggen_round_robin_selector
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [HOSTS-1:0] i_request,
  input  logic             i_accept,
  input  logic [HOSTS-1:0] i_grant,
  output logic [HOSTS-1:0] o_select
);

  localparam int IW = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  logic [IW-1:0]                 last_grant_q;
  logic [IW-1:0]                 last_grant_d;
  logic [RGGEN_RR_MAX_HOSTS-1:0] select_all;
  logic                          unused_select;

  always_comb begin
    last_grant_d = last_grant_q;
    if (i_accept) begin
      for (int i = 0; i < HOSTS; i++) begin
        if (i_grant[i]) begin
          last_grant_d = IW'(i);
        end
      end
    end
  end

  // Pointer resets to the top host so host 0 wins the first arbitration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant_q <= IW'(HOSTS - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign select_all    = rggen_rr_select(RGGEN_RR_MAX_HOSTS'(i_request),
                                         5'(last_grant_q), 6'(HOSTS));
  assign o_select      = select_all[HOSTS-1:0];
  assign unused_select = ^select_all;

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one register bus target between several hosts;
// latches the winning request and routes the response back to the winner only.
module rggen_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS         = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [HOSTS-1:0]               i_host_valid,
  input  logic [2*HOSTS-1:0]             i_host_access,
  input  logic [ADDRESS_WIDTH*HOSTS-1:0] i_host_address,
  input  logic [BUS_WIDTH*HOSTS-1:0]     i_host_write_data,
  input  logic [BUS_WIDTH/8*HOSTS-1:0]   i_host_strobe,
  output logic [HOSTS-1:0]               o_host_ready,
  output logic [2*HOSTS-1:0]             o_host_status,
  output logic [BUS_WIDTH*HOSTS-1:0]     o_host_read_data,
  output logic                           o_target_valid,
  output logic [1:0]                     o_target_access,
  output logic [ADDRESS_WIDTH-1:0]       o_target_address,
  output logic [BUS_WIDTH-1:0]           o_target_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_target_strobe,
  input  logic                           i_target_ready,
  input  logic [1:0]                     i_target_status,
  input  logic [BUS_WIDTH-1:0]           i_target_read_data,
  output logic [HOSTS-1:0]               o_grant,
  output logic                           o_busy
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = BUS_WIDTH;
  localparam int SW = BUS_WIDTH / 8;

  rggen_bus_arbiter_state state_q;
  rggen_bus_arbiter_state state_d;
  logic [HOSTS-1:0]       grant_q;
  logic [HOSTS-1:0]       grant_d;
  logic [HOSTS-1:0]       select;
  logic                   capture;
  logic                   accept;

  logic [1:0]             access_q;
  logic [AW-1:0]          address_q;
  logic [DW-1:0]          write_data_q;
  logic [SW-1:0]          strobe_q;

  logic [1:0]             sel_access;
  logic [AW-1:0]          sel_address;
  logic [DW-1:0]          sel_write_data;
  logic [SW-1:0]          sel_strobe;

  rggen_round_robin_selector #(
    .HOSTS (HOSTS)
  ) u_selector (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_request (i_host_valid),
    .i_accept  (accept),
    .i_grant   (grant_q),
    .o_select  (select)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_host_valid) begin
          state_d = BUSY;
          grant_d = select;
          capture = 1'b1;
        end
      end
      BUSY: begin
        if (i_target_ready) begin
          state_d = IDLE;
          grant_d = '0;
          accept  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    sel_access     = '0;
    sel_address    = '0;
    sel_write_data = '0;
    sel_strobe     = '0;
    for (int i = 0; i < HOSTS; i++) begin
      if (select[i]) begin
        sel_access     = i_host_access[2*i +: 2];
        sel_address    = i_host_address[AW*i +: AW];
        sel_write_data = i_host_write_data[DW*i +: DW];
        sel_strobe     = i_host_strobe[SW*i +: SW];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      access_q  <= '0;
      address_q <= '0;
    end else if (capture) begin
      access_q  <= sel_access;
      address_q <= sel_address;
    end
  end

  // Payload registers are only meaningful while valid is high, so no reset.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      write_data_q <= sel_write_data;
      strobe_q     <= sel_strobe;
    end
  end

  always_comb begin
    o_host_ready     = '0;
    o_host_status    = '0;
    o_host_read_data = '0;
    for (int i = 0; i < HOSTS; i++) begin
      o_host_status[2*i +: 2] = RGGEN_OKAY;
      if (grant_q[i]) begin
        o_host_ready[i]              = i_target_ready;
        o_host_status[2*i +: 2]      = i_target_status;
        o_host_read_data[DW*i +: DW] = i_target_read_data;
      end
    end
  end

  assign o_target_valid      = (state_q == BUSY);
  assign o_target_access     = access_q;
  assign o_target_address    = address_q;
  assign o_target_write_data = write_data_q;
  assign o_target_strobe     = strobe_q;
  assign o_grant             = grant_q;
  assign o_busy              = (state_q == BUSY);

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Self-checking bench for rggen_bus_arbiter with two hosts; expected target
// requests are queued as hosts drive them and compared when the target sees them.
module tb_rggen_bus_arbiter;
  import rggen_rtl_pkg::*;

  localparam int HOSTS = 2;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [1:0]  h_valid = '0;
  logic [3:0]  h_access = '0;
  logic [15:0] h_addr = '0;
  logic [63:0] h_wdata = '0;
  logic [7:0]  h_strb = '0;
  logic [1:0]  h_ready;
  logic [3:0]  h_status;
  logic [63:0] h_rdata;
  logic        t_valid;
  logic [1:0]  t_access;
  logic [7:0]  t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_strb;
  logic        t_ready = 1'b0;
  logic [1:0]  t_status = 2'b00;
  logic [31:0] t_rdata = '0;
  logic [1:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          host;
    logic [1:0]  access;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  req_t exp_q[$];

  rggen_bus_arbiter #(
    .HOSTS         (HOSTS),
    .ADDRESS_WIDTH (8),
    .BUS_WIDTH     (32)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_host_valid        (h_valid),
    .i_host_access       (h_access),
    .i_host_address      (h_addr),
    .i_host_write_data   (h_wdata),
    .i_host_strobe       (h_strb),
    .o_host_ready        (h_ready),
    .o_host_status       (h_status),
    .o_host_read_data    (h_rdata),
    .o_target_valid      (t_valid),
    .o_target_access     (t_access),
    .o_target_address    (t_addr),
    .o_target_write_data (t_wdata),
    .o_target_strobe     (t_strb),
    .i_target_ready      (t_ready),
    .i_target_status     (t_status),
    .i_target_read_data  (t_rdata),
    .o_grant             (grant),
    .o_busy              (busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_host(input int h, input logic v, input logic [1:0] acc,
                            input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit push);
    req_t r;
    h_valid[h]          = v;
    h_access[2*h +: 2]  = acc;
    h_addr[8*h +: 8]    = a;
    h_wdata[32*h +: 32] = d;
    h_strb[4*h +: 4]    = s;
    if (push) begin
      r.host = h; r.access = acc; r.addr = a; r.wdata = d; r.strb = s;
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_target_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (t_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    t_ready = 1'b0;
    i_rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({t_valid, busy, grant, h_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid/busy/grant/ready got %b want 000000",
               {t_valid, busy, grant, h_ready});
    end
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (t_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: target valid got %b want 0", t_valid);
    end
  endtask

  task automatic test_single_write();
    req_t e;
    t_ready = 1'b1; t_status = RGGEN_OKAY; t_rdata = '0;
    drive_host(0, 1'b1, RGGEN_WRITE, 8'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    #1;
    checks++;
    if ({t_valid, h_ready} !== 3'b000) begin
      errors++;
      $display("FAIL single_pre_edge: valid/ready got %b want 000", {t_valid, h_ready});
    end
    tick();
    checks++;
    if (t_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL single_latency: target valid got %b want 1", t_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({t_access, t_addr, t_wdata, t_strb} !== {e.access, e.addr, e.wdata, e.strb}) begin
        errors++;
        $display("FAIL single_fields: got %h want %h", {t_access, t_addr, t_wdata, t_strb},
                 {e.access, e.addr, e.wdata, e.strb});
      end
      checks++;
      if ({grant, busy} !== {2'(1 << e.host), 1'b1}) begin
        errors++;
        $display("FAIL single_grant: grant/busy got %b want %b", {grant, busy},
                 {2'(1 << e.host), 1'b1});
      end
      checks++;
      if ({h_ready, h_status[1:0]} !== {2'b01, 2'(RGGEN_OKAY)}) begin
        errors++;
        $display("FAIL single_response: ready/status got %b want 0100", {h_ready, h_status[1:0]});
      end
    end
    drive_host(0, 1'b0, RGGEN_READ, 8'h00, 32'h0, 4'h0, 1'b0);
    tick();
    checks++;
    if ({t_valid, busy, grant, h_ready} !== 6'b0) begin
      errors++;
      $display("FAIL single_back_idle: valid/busy/grant/ready got %b want 000000",
               {t_valid, busy, grant, h_ready});
    end
  endtask

  task automatic test_simultaneous();
    req_t e;
    req_t r;
    bit   ok;
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;
    tick();
    t_ready = 1'b1;
    drive_host(0, 1'b1, RGGEN_WRITE, 8'h20, 32'h0000_0A0A, 4'hF, 1'b0);
    drive_host(1, 1'b1, RGGEN_WRITE, 8'h30, 32'h0000_0B0B, 4'h3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      r.host   = k % 2;
      r.access = RGGEN_WRITE;
      r.addr   = (k % 2 == 0) ? 8'h20 : 8'h30;
      r.wdata  = (k % 2 == 0) ? 32'h0000_0A0A : 32'h0000_0B0B;
      r.strb   = (k % 2 == 0) ? 4'hF : 4'h3;
      exp_q.push_back(r);
    end
    for (int k = 0; k < 4; k++) begin
      wait_target_valid(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rr_timeout: transaction %0d target valid got 0 want 1", k);
      end else begin
        e = exp_q.pop_front();
        if ({grant, t_addr, t_wdata, t_strb} !== {2'(1 << e.host), e.addr, e.wdata, e.strb}) begin
          errors++;
          $display("FAIL rr_order: transaction %0d grant/addr got %b/%h want %b/%h", k,
                   grant, t_addr, 2'(1 << e.host), e.addr);
        end
      end
      tick();
    end
    h_valid = 2'b00;
    tick();
  endtask

  task automatic test_stall();
    req_t e;
    bit   ok;
    int   pulses;
    pulses  = 0;
    t_ready = 1'b0;
    drive_host(0, 1'b1, RGGEN_WRITE, 8'h40, 32'hCAFE_0040, 4'hC, 1'b1);
    drive_host(1, 1'b1, RGGEN_WRITE, 8'h50, 32'hCAFE_0050, 4'h5, 1'b1);
    wait_target_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout: target valid got 0 want 1");
      return;
    end
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({t_valid, grant, t_addr, t_wdata, t_strb} !== {1'b1, 2'(1 << e.host), e.addr, e.wdata, e.strb}) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d valid/grant/addr got %b/%b/%h want 1/%b/%h", c,
                 t_valid, grant, t_addr, 2'(1 << e.host), e.addr);
      end
      if (h_ready != 2'b00) pulses++;
      tick();
    end
    t_ready = 1'b1;
    #1;
    checks++;
    if ({h_ready, t_addr, t_wdata} !== {2'b01, e.addr, e.wdata}) begin
      errors++;
      $display("FAIL stall_release: ready/addr got %b/%h want 01/%h", h_ready, t_addr, e.addr);
    end
    if (h_ready != 2'b00) pulses++;
    drive_host(0, 1'b0, RGGEN_READ, 8'h00, 32'h0, 4'h0, 1'b0);
    tick();
    if (h_ready != 2'b00) pulses++;
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL stall_pulses: ready pulses got %0d want 1", pulses);
    end
    wait_target_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_next_timeout: target valid got 0 want 1");
    end else begin
      e = exp_q.pop_front();
      if ({grant, h_ready, t_addr} !== {2'(1 << e.host), 2'(1 << e.host), e.addr}) begin
        errors++;
        $display("FAIL stall_loser_next: grant/ready/addr got %b/%b/%h want %b/%b/%h",
                 grant, h_ready, t_addr, 2'(1 << e.host), 2'(1 << e.host), e.addr);
      end
    end
    drive_host(1, 1'b0, RGGEN_READ, 8'h00, 32'h0, 4'h0, 1'b0);
    tick();
  endtask

  task automatic test_read_routing();
    req_t e;
    bit   ok;
    t_ready  = 1'b1;
    t_status = RGGEN_SLAVE_ERROR;
    t_rdata  = 32'h1234_5678;
    drive_host(1, 1'b1, RGGEN_READ, 8'h04, 32'h0, 4'h0, 1'b1);
    wait_target_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_timeout: target valid got 0 want 1");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({grant, t_access, t_addr} !== {2'(1 << e.host), e.access, e.addr}) begin
        errors++;
        $display("FAIL read_request: grant/access/addr got %b/%b/%h want %b/%b/%h",
                 grant, t_access, t_addr, 2'(1 << e.host), e.access, e.addr);
      end
      checks++;
      if ({h_ready, h_status[3:2], h_rdata[63:32]} !== {2'b10, 2'(RGGEN_SLAVE_ERROR), 32'h1234_5678}) begin
        errors++;
        $display("FAIL read_host1: ready/status/data got %b/%b/%h want 10/10/12345678",
                 h_ready, h_status[3:2], h_rdata[63:32]);
      end
      checks++;
      if ({h_status[1:0], h_rdata[31:0]} !== {2'(RGGEN_OKAY), 32'h0}) begin
        errors++;
        $display("FAIL read_host0_quiet: status/data got %b/%h want 00/00000000",
                 h_status[1:0], h_rdata[31:0]);
      end
    end
    drive_host(1, 1'b0, RGGEN_READ, 8'h00, 32'h0, 4'h0, 1'b0);
    tick();
    t_status = RGGEN_OKAY;
    t_rdata  = '0;
  endtask

  task automatic test_drop_valid();
    req_t e;
    bit   ok;
    t_ready = 1'b0;
    drive_host(0, 1'b1, RGGEN_WRITE, 8'h3C, 32'hA5A5_0F0F, 4'h3, 1'b1);
    wait_target_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drop_timeout: target valid got 0 want 1");
      return;
    end
    e = exp_q.pop_front();
    drive_host(0, 1'b0, RGGEN_WRITE, 8'hFF, 32'hFFFF_FFFF, 4'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({t_valid, h_ready, t_addr, t_wdata, t_strb} !== {1'b1, 2'b00, e.addr, e.wdata, e.strb}) begin
        errors++;
        $display("FAIL drop_hold: cycle %0d valid/ready/addr/data got %b/%b/%h/%h want 1/00/%h/%h",
                 c, t_valid, h_ready, t_addr, t_wdata, e.addr, e.wdata);
      end
    end
    t_ready = 1'b1;
    #1;
    checks++;
    if ({h_ready, t_addr, t_wdata} !== {2'b01, e.addr, e.wdata}) begin
      errors++;
      $display("FAIL drop_complete: ready/addr/data got %b/%h/%h want 01/%h/%h",
               h_ready, t_addr, t_wdata, e.addr, e.wdata);
    end
    tick();
    checks++;
    if (t_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_repeat: target valid got %b want 0", t_valid);
    end
  endtask

  task automatic test_reset_mid_busy();
    req_t e;
    bit   ok;
    t_ready = 1'b0;
    drive_host(1, 1'b1, RGGEN_WRITE, 8'h60, 32'h0000_0060, 4'hF, 1'b1);
    wait_target_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_busy_timeout: target valid got 0 want 1");
    end else begin
      e = exp_q.pop_front();
      if (grant !== 2'(1 << e.host)) begin
        errors++;
        $display("FAIL rst_busy_grant: grant got %b want %b", grant, 2'(1 << e.host));
      end
    end
    #2;
    t_ready = 1'b1;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({t_valid, busy, grant, h_ready} !== 6'b0) begin
      errors++;
      $display("FAIL rst_async: valid/busy/grant/ready got %b want 000000",
               {t_valid, busy, grant, h_ready});
    end
    drive_host(1, 1'b0, RGGEN_READ, 8'h00, 32'h0, 4'h0, 1'b0);
    tick();
    i_rst_n = 1'b1;
    drive_host(0, 1'b1, RGGEN_WRITE, 8'h70, 32'h0000_0070, 4'h1, 1'b1);
    drive_host(1, 1'b1, RGGEN_WRITE, 8'h74, 32'h0000_0074, 4'h2, 1'b0);
    wait_target_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_after_timeout: target valid got 0 want 1");
    end else begin
      e = exp_q.pop_front();
      if ({grant, t_addr} !== {2'(1 << e.host), e.addr}) begin
        errors++;
        $display("FAIL rst_after_winner: grant/addr got %b/%h want %b/%h",
                 grant, t_addr, 2'(1 << e.host), e.addr);
      end
    end
    h_valid = 2'b00;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got 200000 want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_stall();
    test_read_routing();
    test_drop_valid();
    test_reset_mid_busy();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending entries got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
